// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode holding {pc, pc+4, instr} entries in FIFO order.
// Latency: a pushed entry reaches the head one cycle after the push (no fall-through).
// Backpressure: fetch_stall when full and decode is not consuming; flush drops everything.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push_valid,
  input  logic [31:0]               push_pc,
  input  logic [31:0]               push_pc_plus4,
  input  logic [31:0]               push_instr,
  output logic                      fetch_stall,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [31:0]               id_pc,
  output logic [31:0]               id_pc_plus4,
  output logic [31:0]               id_instr,
  output logic                      id_misalign,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Entry storage; contents are only meaningful where count says so, so no reset.
  logic [31:0] slot_pc_q    [DEPTH];
  logic [31:0] slot_pc4_q   [DEPTH];
  logic [31:0] slot_instr_q [DEPTH];

  logic pop;
  logic push;
  logic not_empty;
  logic full;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);

  // Handshake decode: a same-cycle pop frees a slot for the incoming push; flush beats both.
  always_comb begin
    pop  = not_empty & id_ready & ~flush;
    push = push_valid & ~flush & (~full | pop);
  end

  // Next pointer/occupancy; flush returns the queue to its reset shape.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture the fetched entry verbatim at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_pc_q[wr_ptr_q]    <= push_pc;
      slot_pc4_q[wr_ptr_q]   <= push_pc_plus4;
      slot_instr_q[wr_ptr_q] <= push_instr;
    end
  end

  // Head presentation; when empty the pc fields are don't-care and are driven to zero.
  always_comb begin
    id_valid    = not_empty;
    id_pc       = '0;
    id_pc_plus4 = '0;
    id_instr    = NOP;
    id_misalign = 1'b0;
    if (not_empty) begin
      id_pc       = slot_pc_q[rd_ptr_q];
      id_pc_plus4 = slot_pc4_q[rd_ptr_q];
      id_instr    = slot_instr_q[rd_ptr_q];
      id_misalign = |slot_pc_q[rd_ptr_q][1:0];
    end
  end

  assign fetch_stall = full & ~id_ready;
  assign count       = count_q;

endmodule
